// File: rtl/sisc_pkg.sv
// Shared types and constants for the memory arbiter slice.
package sisc_pkg;

   localparam int unsigned DEF_AW = 16;
   localparam int unsigned DEF_DW = 32;

   // Owner encoding, also the value carried on gnt_d
   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_D  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and data requests.
// Build option MEM_ARB_RR_EN: on a tie, grant the requester not served last.
// Without it, data always beats fetch.
module arb_pick
   import sisc_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
   input  logic last_owner,
   output logic owner
);

   // Pick the owner for a transaction starting this cycle
   always_comb begin
      owner = OWNER_IF;
`ifdef MEM_ARB_RR_EN
      if (if_req && d_req) begin
         owner = ~last_owner;
      end else if (d_req) begin
         owner = OWNER_D;
      end
`else
      if (d_req) begin
         owner = OWNER_D;
      end
`endif
   end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-ported memory between instruction fetch and data access.
// One transaction at a time: IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE -> IDLE.
// Tie-break policy lives in arb_pick; build option MEM_ARB_RR_EN selects
// round-robin, otherwise fixed data-over-fetch priority.
module mem_arb
   import sisc_pkg::*;
#(
   parameter int unsigned AW  = DEF_AW,
   parameter int unsigned DW  = DEF_DW,
   parameter int unsigned LAT = 2
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          gnt_d
);

   localparam logic [3:0] LAT_CNT = 4'(LAT);

   arb_state_t state;
   logic [3:0] cnt;
   logic       we_q;   // latched store flag of the current transaction
   logic       owner;

   arb_pick u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
      .last_owner (gnt_d),
      .owner      (owner)
   );

   // Transaction sequencer with registered memory-side and ack outputs
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         busy      <= 1'b0;
         gnt_d     <= 1'b0;
      end else begin
         // Strobes and acks are single-cycle pulses
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         unique case (state)
            IDLE: begin
               if (if_req || d_req) begin
                  state    <= ISSUE;
                  busy     <= 1'b1;
                  gnt_d    <= owner;
                  cnt      <= LAT_CNT;
                  mem_en   <= 1'b1;
                  mem_we   <= (owner == OWNER_D) && d_we;
                  we_q     <= (owner == OWNER_D) && d_we;
                  mem_addr <= (owner == OWNER_D) ? d_addr : if_addr;
                  // Fetches carry no write data; keep the last store value
                  if (owner == OWNER_D) begin
                     mem_wdata <= d_wdata;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= DONE;
                  if (!we_q) begin
                     rdata <= mem_rdata;
                  end
                  if_ack <= (gnt_d == OWNER_IF);
                  d_ack  <= (gnt_d == OWNER_D);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb. Expected ack owner/data are queued when a
// request is raised and popped when the matching ack appears.
module tb_mem_arb;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 2;

   logic          clk = 1'b0;
   logic          rst_f;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          if_ack, d_ack;
   logic [DW-1:0] rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy, gnt_d;

   typedef struct {
      logic          owner;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_if_ack = 0;
   logic [LAT-1:0] pipe = '0;

   always #5 clk = ~clk;

   mem_arb #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
      .clk       (clk),
      .rst_f     (rst_f),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .gnt_d     (gnt_d)
   );

   function automatic logic [DW-1:0] memv(input logic [AW-1:0] a);
      return (a == 16'h0010) ? 32'h1234_5678 : {16'hA5A5, a};
   endfunction

   // Memory model: read data is valid only exactly LAT cycles after mem_en
   always @(posedge clk) pipe <= {pipe[LAT-2:0], mem_en};
   assign mem_rdata = pipe[LAT-1] ? memv(mem_addr) : 32'h0BAD_0BAD;

   always @(posedge clk) if (if_ack) n_if_ack++;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
   endtask

   task automatic apply_reset;
      rst_f = 1'b0;
      tick; tick;
      rst_f = 1'b1;
   endtask

   // Advance until an ack appears (bounded); report cycles relative to start
   task automatic run_until_ack(input int start, output int ack_cyc, output int en_cyc,
                                output logic ack_own, output logic [DW-1:0] ack_data);
      ack_cyc = -1; en_cyc = -1; ack_own = 1'bx; ack_data = 'x;
      for (int k = 1; k <= 30; k++) begin
         tick;
         if (mem_en && en_cyc < 0) en_cyc = start + k;
         if (if_ack || d_ack) begin
            ack_cyc  = start + k;
            ack_own  = d_ack;
            ack_data = rdata;
            break;
         end
      end
   endtask

   task automatic test_reset;
      clear_reqs; if_addr = '0; d_addr = '0; d_wdata = '0;
      apply_reset;
      n_checks++;
      if ({if_ack, d_ack, mem_en, mem_we, busy, gnt_d, mem_addr, mem_wdata, rdata} !== '0)
         $display("FAIL reset_outputs: got ack=%b%b en=%b we=%b busy=%b gnt_d=%b addr=%h wdata=%h rdata=%h want all 0",
                  if_ack, d_ack, mem_en, mem_we, busy, gnt_d, mem_addr, mem_wdata, rdata);
      else n_pass++;
   endtask

   task automatic test_fetch;
      exp_t e;
      sb.push_back('{owner: 1'b0, data: 32'h1234_5678});
      if_req = 1'b1; if_addr = 16'h0010;           // cycle 0
      tick;                                       // cycle 1
      n_checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010 || busy !== 1'b1)
         $display("FAIL fetch_issue: got en=%b we=%b addr=%h busy=%b want en=1 we=0 addr=0010 busy=1",
                  mem_en, mem_we, mem_addr, busy);
      else n_pass++;
      tick; tick;                                 // cycle 3
      n_checks++;
      if (if_ack !== 1'b0) $display("FAIL fetch_early_ack: got if_ack=%b in cycle 3 want 0", if_ack);
      else n_pass++;
      tick;                                       // cycle 4
      e = sb.pop_front();
      n_checks++;
      if (if_ack !== 1'b1 || d_ack !== 1'b0 || gnt_d !== e.owner)
         $display("FAIL fetch_ack: got if_ack=%b d_ack=%b gnt_d=%b want 1 0 %b", if_ack, d_ack, gnt_d, e.owner);
      else n_pass++;
      n_checks++;
      if (rdata !== e.data) $display("FAIL fetch_rdata: got %h want %h", rdata, e.data);
      else n_pass++;
      tick;                                       // cycle 5
      if_req = 1'b0;
      n_checks++;
      if (if_ack !== 1'b0 || busy !== 1'b0)
         $display("FAIL fetch_ack_pulse: got if_ack=%b busy=%b in cycle 5 want 0 0", if_ack, busy);
      else n_pass++;
   endtask

   task automatic test_store;
      exp_t e;
      sb.push_back('{owner: 1'b1, data: 32'h1234_5678});  // rdata left untouched
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0080; d_wdata = 32'hDEAD_BEEF;
      for (int c = 1; c <= 4; c++) begin
         tick;
         n_checks++;
         if (mem_addr !== 16'h0080) $display("FAIL store_addr_c%0d: got %h want 0080", c, mem_addr);
         else n_pass++;
         if (c == 1) begin
            n_checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF)
               $display("FAIL store_issue: got en=%b we=%b wdata=%h want 1 1 deadbeef",
                        mem_en, mem_we, mem_wdata);
            else n_pass++;
         end
         if (c == 2) begin
            n_checks++;
            if (mem_en !== 1'b0 || mem_we !== 1'b0)
               $display("FAIL store_strobe_len: got en=%b we=%b in cycle 2 want 0 0", mem_en, mem_we);
            else n_pass++;
         end
      end
      e = sb.pop_front();
      n_checks++;
      if (d_ack !== 1'b1 || if_ack !== 1'b0 || gnt_d !== e.owner || rdata !== e.data)
         $display("FAIL store_ack: got d_ack=%b if_ack=%b gnt_d=%b rdata=%h want 1 0 %b %h",
                  d_ack, if_ack, gnt_d, rdata, e.owner, e.data);
      else n_pass++;
      tick;
      clear_reqs;
   endtask

   task automatic test_latch;
      exp_t e;
      sb.push_back('{owner: 1'b1, data: 32'hA5A5_0080});
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
      for (int c = 1; c <= 4; c++) begin
         tick;
         if (c == 2) d_addr = 16'h00FF;
         if (c >= 2) begin
            n_checks++;
            if (mem_addr !== 16'h0080) $display("FAIL latch_addr_c%0d: got %h want 0080", c, mem_addr);
            else n_pass++;
         end
      end
      e = sb.pop_front();
      n_checks++;
      if (d_ack !== 1'b1 || rdata !== e.data)
         $display("FAIL latch_load: got d_ack=%b rdata=%h want 1 %h", d_ack, rdata, e.data);
      else n_pass++;
      tick;
      clear_reqs;
   endtask

   task automatic test_tie;
      exp_t e;
      int ack_cyc, en_cyc;
      logic own;
      logic [DW-1:0] dat;
      apply_reset;                                // last owner = fetch for either policy
      sb.push_back('{owner: 1'b1, data: 32'hA5A5_0040});
      sb.push_back('{owner: 1'b0, data: 32'h1234_5678});
      if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
      run_until_ack(0, ack_cyc, en_cyc, own, dat);
      e = sb.pop_front();
      n_checks++;
      if (ack_cyc !== 4 || own !== e.owner || dat !== e.data)
         $display("FAIL tie_first: got cycle=%0d owner=%b rdata=%h want 4 %b %h",
                  ack_cyc, own, dat, e.owner, e.data);
      else n_pass++;
      tick;                                       // cycle 5
      d_req = 1'b0;
      run_until_ack(5, ack_cyc, en_cyc, own, dat);
      e = sb.pop_front();
      n_checks++;
      if (en_cyc !== 6) $display("FAIL tie_fetch_issue: got cycle %0d want 6", en_cyc);
      else n_pass++;
      n_checks++;
      if (ack_cyc !== 9 || own !== e.owner || dat !== e.data)
         $display("FAIL tie_second: got cycle=%0d owner=%b rdata=%h want 9 %b %h",
                  ack_cyc, own, dat, e.owner, e.data);
      else n_pass++;
      tick;
      clear_reqs;
   endtask

   task automatic test_reset_mid;
      int acks = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;   // cycle 0
      tick; tick;                                 // cycle 2 (WAIT)
      rst_f = 1'b0;
      tick;                                       // cycle 3
      rst_f = 1'b1;
      clear_reqs;
      n_checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0 || rdata !== '0 || d_ack !== 1'b0 || if_ack !== 1'b0)
         $display("FAIL reset_mid: got busy=%b en=%b rdata=%h acks=%b%b want 0 0 0 00",
                  busy, mem_en, rdata, if_ack, d_ack);
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
         tick;
         if (if_ack || d_ack) acks++;
      end
      n_checks++;
      if (acks !== 0) $display("FAIL reset_mid_no_ack: got %0d acks want 0", acks);
      else n_pass++;
   endtask

   task automatic test_hold;
      exp_t e;
      int ack_cyc, en_cyc, base, if_before;
      logic own;
      logic [DW-1:0] dat;
      apply_reset;
      for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
         if (t % 2 == 0) sb.push_back('{owner: 1'b1, data: 32'hA5A5_0040});
         else sb.push_back('{owner: 1'b0, data: 32'h1234_5678});
`else
         sb.push_back('{owner: 1'b1, data: 32'hA5A5_0040});
`endif
      end
      if_before = n_if_ack;
      if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
      base = 0;
      for (int t = 0; t < 4; t++) begin
         run_until_ack(base, ack_cyc, en_cyc, own, dat);
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL hold_sb_empty: got empty queue want entry %0d", t);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if (own !== e.owner || dat !== e.data)
               $display("FAIL hold_txn%0d: got owner=%b rdata=%h want %b %h", t, own, dat, e.owner, e.data);
            else n_pass++;
         end
         n_checks++;
         if (ack_cyc !== 4 + 5 * t) $display("FAIL hold_cycle%0d: got %0d want %0d", t, ack_cyc, 4 + 5 * t);
         else n_pass++;
         base = ack_cyc;
      end
      n_checks++;
`ifdef MEM_ARB_RR_EN
      if (n_if_ack - if_before !== 2) $display("FAIL hold_if_acks: got %0d want 2", n_if_ack - if_before);
`else
      if (n_if_ack - if_before !== 0) $display("FAIL hold_if_acks: got %0d want 0", n_if_ack - if_before);
`endif
      else n_pass++;
      tick;
      clear_reqs;
      tick; tick;
   endtask

   initial begin
      rst_f = 1'b0;
      test_reset;
      test_fetch;
      test_store;
      test_latch;
      test_tie;
      test_reset_mid;
      test_hold;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Sequencer/arbiter that shares one single-ported unified memory between the instruction-fetch path (PC→IR) and the data path (LOD/STR via the address mux).
- Accepts requests from both, grants one, drives the memory port through a fixed-latency access, and returns read data with a one-cycle ack pulse.
- Sits between pc/ir/ctrl and the memory. The ctrl FSM stalls on req-without-ack.

Parameters:
- AW, 16, memory address width (matches PC width).
- DW, 32, data/instruction width.
- LAT, 2, memory read latency in cycles after the issue cycle; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_f  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse; rdata holds the instruction.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse; load data is on rdata.
- rdata  out  DW  registered read data; held until the next capture.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, only together with mem_en.
- mem_addr  out  AW  registered address, stable from issue through done.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.
- gnt_d  out  1  owner of the current or last transaction (1 = data, 0 = fetch).

Behaviour:
- Reset (rst_f=0 at an edge): state IDLE, wait counter 0. All outputs 0: acks, mem_en, mem_we, mem_addr, mem_wdata, rdata, busy, gnt_d.
- States and transitions:
  - IDLE → ISSUE when any request is high.
  - ISSUE → WAIT, always.
  - WAIT → DONE when the counter expires.
  - DONE → IDLE, always.
- Arbitration: winner picked in IDLE only. Default is fixed priority, data over fetch. There is no preemption once ISSUE is entered.
- On IDLE→ISSUE: latch the winner's addr, we and wdata into the mem_* registers; set gnt_d; load counter with LAT.
- ISSUE (1 cycle): mem_en=1; mem_we = latched we if owner is data, else 0.
- WAIT (LAT cycles): counter decrements each cycle. On the last WAIT cycle, mem_rdata is captured into rdata (loads and fetches only; rdata is unchanged for stores).
- DONE (1 cycle): ack to the owner (if_ack or d_ack) = 1; the other ack stays 0.
- Timing: req seen in IDLE at cycle 0 → mem_en in cycle 1 → ack in cycle LAT+2. Stores use identical timing.
- Requester deasserts req in the cycle after ack. Since DONE always returns to IDLE, there is a one-cycle turnaround and no double grant.
- Requester addr/wdata changes after ISSUE are ignored (latched copies).
- A request dropped before ack: the transaction still completes and the ack still pulses.
- Reset mid-transaction: abandoned immediately. No ack, mem_en=0 next cycle, rdata cleared.
- busy=1 in ISSUE, WAIT and DONE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on a tie. When both requests are high in IDLE, grant the requester not served last (tracked by gnt_d). A single requester is always granted.
- Undefined: fixed data-over-fetch priority. A continuously held d_req may starve fetch; this is acceptable because ctrl serialises its own accesses.

Decomposition:
- Shared package sisc_pkg:
  - arb_state_t enum: IDLE, ISSUE, WAIT, DONE.
  - AW/DW default constants.
  - OWNER_IF=0 and OWNER_D=1 encodings.
- Sub-module arb_pick: combinational winner select, inputs if_req, d_req, last owner; output owner. Holds the MEM_ARB_RR_EN variant so the FSM is unchanged between builds.

Test Plan:
- Fetch only, LAT=2: if_req=1, if_addr=0x0010, memory returns 0x12345678 → mem_en in cycle 1, mem_addr=0x0010, if_ack in cycle 4 only, rdata=0x12345678, d_ack=0, gnt_d=0.
- Store: d_req=1, d_we=1, d_addr=0x0080, d_wdata=0xDEADBEEF → mem_en=mem_we=1 in cycle 1 only; mem_addr=0x0080 held in cycles 1–4; d_ack in cycle 4; rdata unchanged.
- Tie, fixed priority: if_req and d_req rise in cycle 0 → d_ack in cycle 4, fetch issued in cycle 6, if_ack in cycle 9.
- Reset mid-WAIT: rst_f=0 in cycle 2 → cycle 3 in IDLE, busy=0, mem_en=0, rdata=0, no ack.
- Latch check: d_addr changed from 0x0080 to 0x00FF in cycle 2 → mem_addr stays 0x0080 through DONE.
- Both requests held continuously for 4 transactions:
  - With MEM_ARB_RR_EN: owners D, F, D, F.
  - Without it: D, D, D, D, and if_ack never pulses.
